// File: rtl/mac_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mac_job_arbiter
//  Purpose  : Arbitrates two requesters onto one shared combinational
//             multiplier and accumulates a dot product per granted job.
//             Round-robin between simultaneous requests; one beat per cycle.
//  Ports    : clk, reset         - clock, synchronous active-high reset
//             req_start/req_len  - per-requester job request and beat count
//             req_valid/req_a/b  - per-requester operand beats
//             req_ready          - beat accept (valid & ready)
//             req_grant          - one-cycle grant pulse in the grant cycle
//             mul_a/mul_b/mul_p  - shared multiplier operands / product
//             res_data/res_id    - accumulated result and owning requester
//             res_valid/ready    - result handshake
//             busy               - high whenever not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module mac_job_arbiter #(
   parameter int DATA_W = 64,
   parameter int ACC_W  = 200,
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          req_start,
   input  logic [2*LEN_W-1:0]  req_len,
   input  logic [1:0]          req_valid,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   output logic [1:0]          req_ready,
   output logic [1:0]          req_grant,
   output logic [DATA_W-1:0]   mul_a,
   output logic [DATA_W-1:0]   mul_b,
   input  logic [2*DATA_W-1:0] mul_p,
   output logic [ACC_W-1:0]    res_data,
   output logic                res_id,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               id_q, id_d;
   logic               rr_q, rr_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               busy_q, busy_d;
   logic               res_valid_q, res_valid_d;
   logic [1:0]         ready_q, ready_d;

   logic               grant_any;
   logic               grant_id;
   logic [LEN_W-1:0]   len_sel;
   logic               beat;
   logic [ACC_W-1:0]   prod_ext;

   // Product is zero-extended (or truncated) to the accumulator width; the
   // accumulator then wraps modulo 2^ACC_W.
   assign prod_ext = ACC_W'(mul_p);

   always_comb begin
      grant_any = (state_q == ST_IDLE) && (req_start != 2'b00);
      // Sole requester wins; on contention the round-robin pointer decides.
      if (req_start == 2'b11) begin
         grant_id = rr_q;
      end else begin
         grant_id = req_start[1];
      end
      len_sel = grant_id ? req_len[LEN_W +: LEN_W] : req_len[0 +: LEN_W];
      beat    = (state_q == ST_RUN) && req_valid[id_q];

      state_d = state_q;
      id_d    = id_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               id_d    = grant_id;
               rr_d    = ~grant_id;
               cnt_d   = len_sel;
               acc_d   = '0;
               state_d = (len_sel == '0) ? ST_RESULT : ST_RUN;
            end
         end
         ST_RUN: begin
            if (beat) begin
               acc_d = acc_q + prod_ext;
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = ST_RESULT;
               end
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered: decode them from the next state.
      busy_d      = (state_d != ST_IDLE);
      res_valid_d = (state_d == ST_RESULT);
      ready_d     = (state_d == ST_RUN) ? (id_d ? 2'b10 : 2'b01) : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         id_q        <= 1'b0;
         rr_q        <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         ready_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         ready_q     <= ready_d;
      end
   end

   // The grant must pulse in the IDLE cycle that takes the decision, so it
   // is decoded directly; it is suppressed while reset is asserted.
   assign req_grant = (grant_any && !reset) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

   assign req_ready = ready_q;
   assign mul_a     = (state_q == ST_RUN) ? req_a[id_q*DATA_W +: DATA_W] : '0;
   assign mul_b     = (state_q == ST_RUN) ? req_b[id_q*DATA_W +: DATA_W] : '0;
   assign res_data  = acc_q;
   assign res_id    = id_q;
   assign res_valid = res_valid_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/mac_job_arbiter.md
MAC_JOB_ARBITER -- requirements
Module: mac_job_arbiter

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, operand width per beat.
REQ-002 SHALL provide parameter ACC_W, default 200, accumulator and result width.
REQ-003 SHALL provide parameter LEN_W, default 8, job-length field width.
REQ-004 SHALL provide port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port req_start  input  2  job request per requester i (level, held until granted).
REQ-007 SHALL provide port req_len  input  2*LEN_W  beat count of requester i's job, slice [i*LEN_W +: LEN_W].
REQ-008 SHALL provide port req_valid  input  2  operand beat valid per requester.
REQ-009 SHALL provide port req_a  input  2*DATA_W  operand A per requester, slice [i*DATA_W +: DATA_W].
REQ-010 SHALL provide port req_b  input  2*DATA_W  operand B per requester, same slicing.
REQ-011 SHALL provide port req_ready  output  2  operand beat accepted when valid&ready.
REQ-012 SHALL provide port req_grant  output  2  one-cycle grant pulse per requester.
REQ-013 SHALL provide port mul_a  output  DATA_W  operand A to the shared combinational multiplier.
REQ-014 SHALL provide port mul_b  output  DATA_W  operand B to the shared multiplier.
REQ-015 SHALL provide port mul_p  input  2*DATA_W  product returned by the multiplier, same cycle.
REQ-016 SHALL provide port res_data  output  ACC_W  accumulated dot-product result.
REQ-017 SHALL provide port res_id  output  1  requester owning res_data.
REQ-018 SHALL provide port res_valid  output  1  result valid.
REQ-019 SHALL provide port res_ready  input  1  result consumer ready.
REQ-020 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement a three-state FSM: IDLE, RUN, RESULT.
REQ-022 In IDLE, with any req_start set, SHALL grant one requester: sole requester wins; if both are set, the round-robin pointer's requester wins.
REQ-023 On grant, SHALL pulse req_grant[id] for that cycle, latch id, load counter with req_len slice, and clear the accumulator to 0.
REQ-024 On grant, SHALL set the round-robin pointer to the non-granted requester.
REQ-025 On grant with len != 0, SHALL go to RUN; with len == 0, SHALL go directly to RESULT with result 0.
REQ-026 In RUN, SHALL drive req_ready[id]=1 and req_ready[other]=0, and drive mul_a/mul_b from the granted requester's req_a/req_b slices.
REQ-027 Outside RUN, SHALL drive mul_a and mul_b to 0 and req_ready to 0.
REQ-028 On each accepted beat, SHALL update acc <= acc + zero-extended mul_p, modulo 2^ACC_W (wrap, no saturation), and decrement the counter.
REQ-029 Throughput SHALL be one beat per cycle; a cycle with req_valid[id]=0 SHALL leave acc and counter unchanged.
REQ-030 When the beat accepted with counter==1 completes, SHALL enter RESULT; res_valid SHALL rise the next cycle.
REQ-031 In RESULT, SHALL hold res_valid=1 with res_data=acc and res_id=id stable until res_ready; on res_valid&res_ready, SHALL return to IDLE.
REQ-032 A non-granted requester's req_start SHALL stay pending and SHALL be considered in the first IDLE cycle after RESULT completes; no grant SHALL occur in RUN or RESULT.
REQ-033 req_start and req_len SHALL be sampled only in the grant cycle; changes mid-job SHALL have no effect.

Reset
REQ-034 While reset is high at a clock edge, SHALL enter IDLE and clear acc, counter, id and res_data to 0, set the round-robin pointer to 0, and drive req_ready, req_grant, res_valid and busy to 0.
REQ-035 Reset asserted in RUN or RESULT SHALL abort the job and discard any pending result.

Verification
REQ-036 Single job: req0 start, len=3, beats (2,3),(4,5),(1,1) -> grant[0] pulse, res_valid 1 cycle after 3rd beat, res_data=27, res_id=0.
REQ-037 Contention: both start at once after reset -> requester 0 granted first, requester 1 granted in the first IDLE cycle after req0's result handshake, then pointer=0.
REQ-038 Stalls: req_valid gaps and res_ready held low 4 cycles -> acc unchanged during gaps, res_data stable, no new grant until handshake.
REQ-039 len=0: req1 start, len=0 -> RESULT next cycle, res_data=0, res_id=1, no req_ready asserted.
REQ-040 Wrap: ACC_W=8, DATA_W=4, beats (15,15)x2 -> res_data=450 mod 256=194.
REQ-041 Reset mid-RUN after 1 of 4 beats -> next cycle IDLE, busy=0, res_valid=0, acc=0; a new job then returns the correct fresh sum.
